// File: rtl/sram_be_2p.sv
// Two-port byte-enabled SRAM with a power-on/reset clearing sweep.
// One write port and one read port on a single clock; reads return after RD_LAT edges.
module sram_be_2p #(
    parameter int DAT_W    = 8,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int RD_LAT   = 1,
    parameter int WR_FIRST = 0,
    localparam int BE_W    = DAT_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DAT_W-1:0]  wr_data,
    input  logic [BE_W-1:0]   wr_be,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DAT_W-1:0]  rd_data,
    output logic              rd_valid,
    output logic              busy
);

    generate
        if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
            $error("sram_be_2p: RD_LAT must be 1 or 2");
        end
        if (DAT_W % 8 != 0 || DAT_W < 8) begin : g_bad_dat_w
            $error("sram_be_2p: DAT_W must be a non-zero multiple of 8");
        end
        if (DEPTH < 2) begin : g_bad_depth
            $error("sram_be_2p: DEPTH must be at least 2");
        end
    endgenerate

    typedef enum logic {INIT, READY} state_t;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

    state_t             state;
    logic [ADDR_W-1:0]  init_ptr;
    logic [DAT_W-1:0]   mem [DEPTH];

    logic               wr_fire;
    logic               rd_fire;
    logic               rd_in_range;
    logic [DAT_W-1:0]   rd_word;
    logic               s1_valid;
    logic [DAT_W-1:0]   s1_data;

    assign busy        = (state == INIT);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_C);
    assign wr_fire     = (state == READY) && wr_en && ({1'b0, wr_addr} < DEPTH_C);
    assign rd_fire     = (state == READY) && rd_en;

    // Out-of-range reads return zero; write-first merges same-edge write bytes.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[rd_addr];
            if (WR_FIRST != 0 && wr_fire && wr_addr == rd_addr) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
                end
            end
        end
    end

    // Array has no reset; the INIT sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[init_ptr] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            init_ptr <= '0;
            s1_valid <= 1'b0;
            s1_data  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            case (state)
                INIT: begin
                    if (init_ptr == LAST_C) begin
                        state    <= READY;
                        init_ptr <= '0;
                    end else begin
                        init_ptr <= init_ptr + 1'b1;
                    end
                end
                default: state <= READY;
            endcase

            // rd_data only moves when a result lands, so it holds between pulses.
            if (RD_LAT == 2) begin
                s1_valid <= rd_fire;
                if (rd_fire) s1_data <= rd_word;
                rd_valid <= s1_valid;
                if (s1_valid) rd_data <= s1_data;
            end else begin
                rd_valid <= rd_fire;
                if (rd_fire) rd_data <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_sram_be_2p.sv
// Directed bench for sram_be_2p: four configurations share one stimulus stream
// (read-first, write-first, two-cycle latency, non-power-of-2 depth).
module tb_sram_be_2p;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        rd_en;
    logic [2:0]  rd_addr;

    logic [15:0] rd_data0, rd_data1, rd_data2, rd_data3;
    logic        rd_valid0, rd_valid1, rd_valid2, rd_valid3;
    logic        busy0, busy1, busy2, busy3;

    int checks = 0;
    int errors = 0;

    // d0: read-first, RD_LAT=1
    sram_be_2p #(.DAT_W(16), .DEPTH(8), .RD_LAT(1), .WR_FIRST(0)) d0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .busy(busy0));

    // d1: write-first, RD_LAT=1
    sram_be_2p #(.DAT_W(16), .DEPTH(8), .RD_LAT(1), .WR_FIRST(1)) d1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .busy(busy1));

    // d2: read-first, RD_LAT=2
    sram_be_2p #(.DAT_W(16), .DEPTH(8), .RD_LAT(2), .WR_FIRST(0)) d2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data2), .rd_valid(rd_valid2), .busy(busy2));

    // d3: DEPTH=6, addresses 6 and 7 are out of range
    sram_be_2p #(.DAT_W(16), .DEPTH(6), .RD_LAT(1), .WR_FIRST(0)) d3 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data3), .rd_valid(rd_valid3), .busy(busy3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and land 1 time unit after it for sampling/driving.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_be   = be;
    endtask

    task automatic rd(input logic [2:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_addr = '0;
        #1 rst = 1'b1;
        #1;
        chk("reset_busy0", 16'(busy0), 16'h1);
        chk("reset_valid0", 16'(rd_valid0), 16'h0);
        chk("reset_data0", rd_data0, 16'h0000);
        chk("reset_busy3", 16'(busy3), 16'h1);
        cyc(); cyc();
        rst = 1'b0;

        // INIT sweep, with requests that must be ignored for the first 5 edges
        wr(3'd7, 16'hFFFF, 2'b11);
        rd(3'd1);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk($sformatf("init_busy0_k%0d", k), 16'(busy0), 16'(k < 8));
            chk($sformatf("init_busy2_k%0d", k), 16'(busy2), 16'(k < 8));
            chk($sformatf("init_busy3_k%0d", k), 16'(busy3), 16'(k < 6));
            if (k <= 5) begin
                chk($sformatf("init_novalid0_k%0d", k), 16'(rd_valid0), 16'h0);
                chk($sformatf("init_novalid2_k%0d", k), 16'(rd_valid2), 16'h0);
            end
            if (k == 5) idle();
        end

        // Read all addresses back to back: all zero
        for (int a = 0; a < 8; a++) begin
            rd(3'(a));
            cyc();
            chk($sformatf("sweep_v0_a%0d", a), 16'(rd_valid0), 16'h1);
            chk($sformatf("sweep_d0_a%0d", a), rd_data0, 16'h0000);
            chk($sformatf("sweep_v3_a%0d", a), 16'(rd_valid3), 16'h1);
            chk($sformatf("sweep_d3_a%0d", a), rd_data3, 16'h0000);
            chk($sformatf("sweep_v2_a%0d", a), 16'(rd_valid2), 16'(a > 0));
        end
        idle();
        cyc();
        chk("sweep_v0_end", 16'(rd_valid0), 16'h0);
        chk("sweep_v2_last", 16'(rd_valid2), 16'h1);
        chk("sweep_d2_last", rd_data2, 16'h0000);
        cyc();
        chk("sweep_v2_end", 16'(rd_valid2), 16'h0);

        // Byte enables on addr 3
        wr(3'd3, 16'hABCD, 2'b01); cyc(); idle();
        rd(3'd3); cyc(); idle();
        chk("be_lo_d0", rd_data0, 16'h00CD);
        chk("be_lo_d3", rd_data3, 16'h00CD);
        cyc();
        chk("be_lo_d2", rd_data2, 16'h00CD);
        chk("hold_v0", 16'(rd_valid0), 16'h0);
        chk("hold_d0", rd_data0, 16'h00CD);
        wr(3'd3, 16'h1234, 2'b10); cyc(); idle();
        wr(3'd3, 16'hFFFF, 2'b00); cyc(); idle();
        rd(3'd3); cyc(); idle();
        chk("be_hi_d0", rd_data0, 16'h12CD);
        chk("be_hi_d1", rd_data1, 16'h12CD);
        cyc();
        chk("be_hi_d2", rd_data2, 16'h12CD);

        // Same-address collisions on addr 5
        wr(3'd5, 16'h0011, 2'b11); cyc(); idle();
        wr(3'd5, 16'h00FF, 2'b11); rd(3'd5); cyc(); idle();
        chk("coll_rf_d0", rd_data0, 16'h0011);
        chk("coll_wf_d1", rd_data1, 16'h00FF);
        chk("coll_rf_d3", rd_data3, 16'h0011);
        cyc();
        chk("coll_rf_d2", rd_data2, 16'h0011);
        wr(3'd5, 16'hAB00, 2'b10); rd(3'd5); cyc(); idle();
        chk("coll2_rf_d0", rd_data0, 16'h00FF);
        chk("coll2_wf_d1", rd_data1, 16'hABFF);
        rd(3'd5); cyc(); idle();
        chk("after_coll_d0", rd_data0, 16'hABFF);
        chk("after_coll_d1", rd_data1, 16'hABFF);
        chk("after_coll_d3", rd_data3, 16'hABFF);
        cyc();

        // RD_LAT=2 pipelining
        wr(3'd0, 16'h000A, 2'b11); cyc();
        wr(3'd1, 16'h000B, 2'b11); cyc();
        wr(3'd2, 16'h000C, 2'b11); cyc(); idle();
        rd(3'd0); cyc();
        chk("pipe1_d0", rd_data0, 16'h000A);
        chk("pipe1_v2", 16'(rd_valid2), 16'h0);
        rd(3'd1); cyc();
        chk("pipe2_d0", rd_data0, 16'h000B);
        chk("pipe2_v2", 16'(rd_valid2), 16'h1);
        chk("pipe2_d2", rd_data2, 16'h000A);
        rd(3'd2); cyc(); idle();
        chk("pipe3_d0", rd_data0, 16'h000C);
        chk("pipe3_v2", 16'(rd_valid2), 16'h1);
        chk("pipe3_d2", rd_data2, 16'h000B);
        cyc();
        chk("pipe4_v0", 16'(rd_valid0), 16'h0);
        chk("pipe4_v2", 16'(rd_valid2), 16'h1);
        chk("pipe4_d2", rd_data2, 16'h000C);
        cyc();
        chk("pipe5_v2", 16'(rd_valid2), 16'h0);
        chk("pipe5_hold_d2", rd_data2, 16'h000C);

        // Out-of-range address on the DEPTH=6 instance
        wr(3'd7, 16'hBEEF, 2'b11); cyc(); idle();
        rd(3'd7); cyc(); idle();
        chk("oor_d0", rd_data0, 16'hBEEF);
        chk("oor_v3", 16'(rd_valid3), 16'h1);
        chk("oor_d3", rd_data3, 16'h0000);
        rd(3'd5); cyc(); idle();
        chk("oor_keep_d3", rd_data3, 16'hABFF);
        cyc();

        // Asynchronous reset with a read in flight
        rd(3'd3); cyc(); idle();
        chk("pre_rst_v0", 16'(rd_valid0), 16'h1);
        chk("pre_rst_d0", rd_data0, 16'h12CD);
        #3 rst = 1'b1;
        #1;
        chk("arst_v0", 16'(rd_valid0), 16'h0);
        chk("arst_d0", rd_data0, 16'h0000);
        chk("arst_busy0", 16'(busy0), 16'h1);
        chk("arst_v2", 16'(rd_valid2), 16'h0);
        chk("arst_d2", rd_data2, 16'h0000);
        cyc();
        chk("arst_nolate_v2a", 16'(rd_valid2), 16'h0);
        cyc();
        chk("arst_nolate_v2b", 16'(rd_valid2), 16'h0);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk($sformatf("reinit_busy0_k%0d", k), 16'(busy0), 16'(k < 8));
            chk($sformatf("reinit_v2_k%0d", k), 16'(rd_valid2), 16'h0);
        end
        rd(3'd3); cyc();
        chk("reinit_v0_a3", 16'(rd_valid0), 16'h1);
        chk("reinit_d0_a3", rd_data0, 16'h0000);
        rd(3'd5); cyc(); idle();
        chk("reinit_d0_a5", rd_data0, 16'h0000);
        chk("reinit_d2_a3", rd_data2, 16'h0000);
        cyc();
        chk("reinit_v2_a5", 16'(rd_valid2), 16'h1);
        chk("reinit_d2_a5", rd_data2, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_be_2p.md
SRAM_BE_2P -- requirements
Module: sram_be_2p

Interface
REQ-001 Parameter DAT_W, default 8: data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 8: number of words; SHALL be >= 2.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH): address width.
REQ-004 Parameter RD_LAT, default 1: read latency in clk edges; SHALL be 1 or 2, with any other value an elaboration error.
REQ-005 Parameter WR_FIRST, default 0: same-address collision mode (0 = read-first, 1 = write-first).
REQ-006 Derived BE_W = DAT_W/8: number of byte enables.
REQ-007 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 wr_en  in  1  write request.
REQ-010 wr_addr  in  ADDR_W  write address.
REQ-011 wr_data  in  DAT_W  write data.
REQ-012 wr_be  in  BE_W  byte enables; bit i covers wr_data[8i+7:8i].
REQ-013 rd_en  in  1  read request.
REQ-014 rd_addr  in  ADDR_W  read address.
REQ-015 rd_data  out  DAT_W  registered read data.
REQ-016 rd_valid  out  1  one-cycle pulse per returned read.
REQ-017 busy  out  1  high while the memory initialises; requests are ignored.

Function
REQ-018 Controller SHALL have two states, INIT and READY; busy SHALL equal (state == INIT).
REQ-019 INIT: each edge SHALL write 0 to mem[init_ptr] and increment init_ptr; at init_ptr == DEPTH-1 it SHALL write that word and move to READY, so busy is high for exactly DEPTH edges after rst deasserts.
REQ-020 In INIT, wr_en and rd_en SHALL be ignored; no read SHALL be accepted and memory SHALL not take user writes.
REQ-021 Read and write ports are independent; in READY both SHALL be accepted on the same edge, including the same address.
REQ-022 Write in READY: on an edge with wr_en=1, bytes with wr_be[i]=1 SHALL take wr_data; bytes with wr_be[i]=0 SHALL keep their old value.
REQ-023 wr_en=1 with wr_be all zero SHALL leave memory unchanged.
REQ-024 Read in READY: rd_en=1 sampled at edge N SHALL drive rd_data with mem[rd_addr] and pulse rd_valid high after edge N+RD_LAT-1 (RD_LAT=1: visible after edge N; RD_LAT=2: after edge N+1).
REQ-025 Back-to-back reads SHALL be accepted every cycle with full throughput and return in order.
REQ-026 rd_data SHALL hold its last value while rd_valid is low.
REQ-027 Collision (rd_en & wr_en, rd_addr == wr_addr, same edge), WR_FIRST=0: returned data SHALL be the pre-write word.
REQ-028 Collision, WR_FIRST=1: returned data SHALL be the byte-enable-merged post-write word.
REQ-029 Address >= DEPTH (non-power-of-2 DEPTH): the write SHALL be dropped; the read SHALL return 0 with rd_valid=1.
REQ-030 Reads accepted in READY SHALL complete even if they are still in the RD_LAT=2 pipeline on the next edge.

Reset
REQ-031 When rst is asserted, the following SHALL take effect immediately, independent of clk: state=INIT, init_ptr=0, busy=1, rd_valid=0, rd_data=0, and all in-flight read pipeline stages cleared.
REQ-032 Reset mid-operation SHALL discard pending reads without any rd_valid pulse, and the block SHALL re-run the full INIT clear.
REQ-033 Memory contents SHALL not be required to clear asynchronously; the INIT sweep SHALL zero them.

Verification
REQ-034 DEPTH=8, DAT_W=16: release rst, then read all addresses -> busy high for 8 cycles; then every read returns 0x0000 with one rd_valid pulse each.
REQ-035 Write 0xABCD to addr 3 with wr_be=2'b01, then read addr 3 -> 0x00CD; then write 0x1234 with be=2'b10 and read -> 0x12CD.
REQ-036 addr 5 = 0x0011, then same-edge write 0x00FF with be=2'b11 and read of addr 5: WR_FIRST=0 -> 0x0011; WR_FIRST=1 -> 0x00FF.
REQ-037 RD_LAT=2, reads of addr 0,1,2 on consecutive edges (contents 0xA,0xB,0xC) -> rd_valid high for 3 consecutive cycles starting one cycle after the RD_LAT=1 timing, data A,B,C in order.
REQ-038 DEPTH=6: write to addr 7 -> no memory change; read of addr 7 -> rd_data=0 with rd_valid=1.
REQ-039 Assert rst asynchronously between edges with a read in flight -> rd_valid and rd_data go 0 immediately, with no late pulse; after release, busy is high 8 cycles and prior contents read back as 0.
